// File: rtl/fpcvt_arbiter_pkg.sv
// fpcvt_arbiter_pkg: shared widths, source tags, FSM states and the saturated-result code.
package fpcvt_arbiter_pkg;

    localparam int DATA_W = 13;
    localparam int MAG_W  = 12;
    localparam int S_W    = 1;
    localparam int E_W    = 3;
    localparam int F_W    = 5;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam logic [E_W-1:0] SAT_E = 3'd7;
    localparam logic [F_W-1:0] SAT_F = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fpcvt_arbiter_fpcvt.sv
// fpcvt_arbiter_fpcvt: 13-bit two's complement to sign/3-bit exponent/5-bit mantissa,
// round half-up, saturating at E=7 F=31.
module fpcvt_arbiter_fpcvt
    import fpcvt_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] d_i,
    output logic              s_o,
    output logic [E_W-1:0]    e_o,
    output logic [F_W-1:0]    f_o
);

    logic [DATA_W-1:0] neg;
    logic [MAG_W-1:0]  mag;
    logic [E_W-1:0]    e;
    logic [5:0]        t;
    logic [F_W:0]      r;

    always_comb begin
        neg = ~d_i + 1'b1;
        // only -4096 sets the carry into bit 12; clamp it to the largest magnitude
        mag = !d_i[DATA_W-1] ? d_i[MAG_W-1:0] : neg[DATA_W-1] ? '1 : neg[MAG_W-1:0];
        e = '0;
        for (int i = 5; i < MAG_W; i++)
            if (mag[i]) e = E_W'(i - 4);
        // t[5:1] is the mantissa window, t[0] the rounding bit (0 when E=0)
        t = 6'({mag, 1'b0} >> e);
        r = {1'b0, t[5:1]} + {5'b0, t[0]};
        s_o = d_i[DATA_W-1];
        e_o = !r[F_W] ? e : (e == SAT_E) ? SAT_E : e + 1'b1;
        f_o = !r[F_W] ? r[F_W-1:0] : (e == SAT_E) ? SAT_F : F_W'(16);
    end

endmodule

// File: rtl/fpcvt_arbiter.sv
// fpcvt_arbiter: round-robin share of one FPCVT between sources A and B, with a
// registered result stage, valid/ready output handshake and a saturated-result counter.
module fpcvt_arbiter
    import fpcvt_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_src,
    output logic [S_W-1:0]    out_s,
    output logic [E_W-1:0]    out_e,
    output logic [F_W-1:0]    out_f,
    output logic [CNT_W-1:0]  sat_cnt
);

    state_t            state_q, state_d;
    logic              last_q;
    logic              tag_q;
    logic [DATA_W-1:0] cap_q;
    logic              gnt_b;
    logic              cv_s;
    logic [E_W-1:0]    cv_e;
    logic [F_W-1:0]    cv_f;
    logic              src_q, s_q;
    logic [E_W-1:0]    e_q;
    logic [F_W-1:0]    f_q;
    logic [CNT_W-1:0]  sat_q;

    fpcvt_arbiter_fpcvt u_fpcvt (
        .d_i (cap_q),
        .s_o (cv_s),
        .e_o (cv_e),
        .f_o (cv_f)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? ((a_valid | b_valid) ? CONV : IDLE) :
                  (state_q == CONV) ? HOLD :
                  out_ready ? IDLE : HOLD;
    end

    // B wins alone, or on a tie when A was served last
    always_comb begin
        gnt_b     = b_valid & (!a_valid | (last_q == SRC_A));
        a_ready   = (state_q == IDLE) & a_valid & !gnt_b;
        b_ready   = (state_q == IDLE) & gnt_b;
        out_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= SRC_B;
            tag_q  <= SRC_A;
            cap_q  <= '0;
            src_q  <= SRC_A;
            s_q    <= 1'b0;
            e_q    <= '0;
            f_q    <= '0;
            sat_q  <= '0;
        end else begin
            if (a_ready | b_ready) begin
                cap_q  <= b_ready ? b_data : a_data;
                tag_q  <= b_ready;
                last_q <= b_ready;
            end
            if (state_q == CONV) begin
                src_q <= tag_q;
                s_q   <= cv_s;
                e_q   <= cv_e;
                f_q   <= cv_f;
            end
            if (out_valid && out_ready && e_q == SAT_E && f_q == SAT_F && sat_q != '1)
                sat_q <= sat_q + 1'b1;
        end
    end

    assign out_src = src_q;
    assign out_s   = s_q;
    assign out_e   = e_q;
    assign out_f   = f_q;
    assign sat_cnt = sat_q;

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// tb_fpcvt_arbiter: table vectors, hand sequences and random traffic checked against
// an arithmetic conversion model and an accept-order scoreboard.
module tb_fpcvt_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, out_ready;
    logic [12:0] a_data, b_data;
    logic        a_ready, b_ready, out_valid, out_src, out_s;
    logic [2:0]  out_e;
    logic [4:0]  out_f;
    logic [7:0]  sat8;
    logic        a_ready2, b_ready2, out_valid2, out_src2, out_s2;
    logic [2:0]  out_e2;
    logic [4:0]  out_f2;
    logic [1:0]  sat2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int nsat = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpcvt_arbiter #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_s(out_s), .out_e(out_e), .out_f(out_f), .sat_cnt(sat8)
    );

    fpcvt_arbiter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_src(out_src2),
        .out_s(out_s2), .out_e(out_e2), .out_f(out_f2), .sat_cnt(sat2)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] pk(input logic src, input logic s, input int e, input int f);
        return {src, s, e[2:0], f[4:0]};
    endfunction

    // Conversion from the arithmetic definition: scale down by 2^E, round half-up.
    function automatic logic [8:0] model(input logic [12:0] d);
        int v, m, e, f;
        logic s;
        v = $signed(d);
        s = (v < 0);
        m = s ? -v : v;
        if (m > 4095) m = 4095;
        e = 0;
        if (m < 32) f = m;
        else begin
            while ((m >> e) >= 32) e++;
            f = (m + (1 << (e - 1))) >> e;
            if (f == 32) begin f = 16; e++; end
            if (e > 7) begin e = 7; f = 31; end
        end
        return {s, e[2:0], f[4:0]};
    endfunction

    typedef struct { int cyc; logic src; logic [12:0] d; } txn_t;
    txn_t q[$];

    logic       prev_ov = 1'b0;
    logic       prev_rdy = 1'b0;
    logic [9:0] prev_out;

    always @(negedge clk) begin
        txn_t t;
        logic [8:0] m;
        if (rst) begin
            q.delete();
            nsat = 0;
            prev_ov = 1'b0;
        end else begin
            chk("one_ready", a_ready & b_ready, 0);
            chk("cnt_w2_same", {a_ready2, b_ready2, out_valid2, out_src2, out_s2, out_e2, out_f2},
                {a_ready, b_ready, out_valid, out_src, out_s, out_e, out_f});
            if (prev_ov && !prev_rdy) chk("hold_stable", {out_src, out_s, out_e, out_f}, prev_out);
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("latency", cyc, q[0].cyc + 2);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_hs", 1, 0);
                else begin
                    t = q.pop_front();
                    m = model(t.d);
                    chk("result", {out_src, out_s, out_e, out_f}, {t.src, m});
                    if (m[7:0] == 8'hFF) nsat++;
                end
            end
            if (a_valid && a_ready) q.push_back('{cyc, 1'b0, a_data});
            if (b_valid && b_ready) q.push_back('{cyc, 1'b1, b_data});
            prev_ov = out_valid;
            prev_rdy = out_ready;
            prev_out = {out_src, out_s, out_e, out_f};
        end
    end

    task automatic xfer(input logic src, input logic [12:0] d, output logic [9:0] r);
        int n;
        @(posedge clk) #1;
        if (src) begin b_valid = 1'b1; b_data = d; end
        else begin a_valid = 1'b1; a_data = d; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(src ? b_ready : a_ready) && n < 20);
        chk("xfer_grant", src ? b_ready : a_ready, 1);
        @(posedge clk) #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("xfer_out", out_valid, 1);
        r = {out_src, out_s, out_e, out_f};
        @(posedge clk);
    endtask

    function automatic logic [12:0] rnd();
        int k;
        k = $urandom_range(0, 5);
        if (k == 0) return $urandom_range(0, 1) ? 13'h0FFF : 13'h1000;
        if (k == 1) return 13'($urandom_range(0, 40));
        return 13'($urandom_range(0, 8191));
    endfunction

    typedef struct { logic src; logic [12:0] d; logic [9:0] exp; } vec_t;
    vec_t tv[13];

    initial begin
        int n, n0;
        logic [9:0] r;
        logic acc_a, acc_b;
        tv[0]  = '{1'b0, 13'h0FFF, pk(0, 0, 7, 31)};
        tv[1]  = '{1'b1, 13'h1000, pk(1, 1, 7, 31)};
        tv[2]  = '{1'b0, 13'd0,    pk(0, 0, 0, 0)};
        tv[3]  = '{1'b0, 13'd1,    pk(0, 0, 0, 1)};
        tv[4]  = '{1'b1, 13'h1FFF, pk(1, 1, 0, 1)};
        tv[5]  = '{1'b0, 13'd16,   pk(0, 0, 0, 16)};
        tv[6]  = '{1'b0, 13'd32,   pk(0, 0, 1, 16)};
        tv[7]  = '{1'b0, 13'd63,   pk(0, 0, 2, 16)};
        tv[8]  = '{1'b0, 13'd2047, pk(0, 0, 7, 16)};
        tv[9]  = '{1'b1, 13'h1E5A, pk(1, 1, 4, 26)};
        tv[10] = '{1'b1, 13'd253,  pk(1, 0, 4, 16)};
        tv[11] = '{1'b0, 13'd110,  pk(0, 0, 2, 28)};
        tv[12] = '{1'b1, 13'd108,  pk(1, 0, 2, 27)};

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {out_valid, out_src, out_s, out_e, out_f}, 0);
        chk("rst_sat", sat8, 0);

        // first transaction: ready in N, result in N+2
        @(posedge clk) #1;
        rst = 1'b0; a_valid = 1'b1; a_data = 13'd422;
        @(negedge clk);
        chk("first_ready", {a_ready, b_ready}, 2'b10);
        n0 = cyc;
        @(posedge clk) #1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("first_n1_valid", out_valid, 0);
        @(negedge clk);
        chk("first_n2_valid", out_valid, 1);
        chk("first_n2_cycle", cyc, n0 + 2);
        chk("first_result", {out_src, out_s, out_e, out_f}, pk(0, 0, 4, 26));
        @(posedge clk) #1;
        @(negedge clk);
        chk("first_idle", out_valid, 0);

        foreach (tv[i]) begin
            xfer(tv[i].src, tv[i].d, r);
            chk($sformatf("table_%0d", i), r, tv[i].exp);
        end
        @(negedge clk);
        chk("table_sat", sat8, 2);

        // both sources held valid: strict A/B alternation
        @(posedge clk) #1;
        a_valid = 1'b1; a_data = 13'd110; b_valid = 1'b1; b_data = 13'd108;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 20);
            chk("alt_valid", out_valid, 1);
            chk($sformatf("alt_%0d", k), {out_src, out_s, out_e, out_f},
                (k % 2) ? pk(1, 0, 2, 27) : pk(0, 0, 2, 28));
            if (k == 3) begin
                @(posedge clk) #1;
                a_valid = 1'b0; b_valid = 1'b0;
            end
        end

        // backpressure in HOLD with A still requesting
        @(posedge clk) #1;
        out_ready = 1'b0; a_valid = 1'b1; a_data = 13'd422;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_ready && n < 20);
        chk("bp_grant", a_ready, 1);
        @(posedge clk) #1;
        a_data = 13'd253;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("bp_valid", out_valid, 1);
        r = {out_src, out_s, out_e, out_f};
        repeat (5) begin
            @(negedge clk);
            chk("bp_held", {out_valid, out_src, out_s, out_e, out_f}, {1'b1, r});
            chk("bp_ready", {a_ready, b_ready}, 0);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 1);
        @(negedge clk);
        chk("bp_idle_valid", out_valid, 0);
        chk("bp_idle_ready", a_ready, 1);
        @(posedge clk) #1;
        a_valid = 1'b0;
        repeat (4) @(posedge clk);

        // reset while converting drops the sample
        @(posedge clk) #1;
        a_valid = 1'b1; a_data = 13'h0FFF;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_ready && n < 20);
        chk("rc_grant", a_ready, 1);
        @(posedge clk) #1;
        rst = 1'b1; a_valid = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rc_no_out", out_valid, 0);
            chk("rc_sat", sat8, 0);
        end
        @(posedge clk) #1;
        a_valid = 1'b1; a_data = 13'd1; b_valid = 1'b1; b_data = 13'd2;
        @(negedge clk);
        chk("rc_a_first", {a_ready, b_ready}, 2'b10);
        @(posedge clk) #1;
        a_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_ready && n < 20);
        chk("rc_b_next", b_ready, 1);
        @(posedge clk) #1;
        b_valid = 1'b0;
        repeat (5) @(posedge clk);

        // five saturated results: 8-bit counter reaches 5, 2-bit counter sticks at 3
        for (int i = 0; i < 5; i++) begin
            xfer(i % 2, (i % 2) ? 13'h1000 : 13'h0FFF, r);
            chk($sformatf("sat_%0d", i), r, pk(i % 2, i % 2, 7, 31));
        end
        @(negedge clk);
        chk("sat_cnt8", sat8, 5);
        chk("sat_cnt2", sat2, 3);

        // random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc_a = a_valid & a_ready;
            acc_b = b_valid & b_ready;
            @(posedge clk) #1;
            if (!a_valid || acc_a) begin a_valid = 1'($urandom_range(0, 1)); a_data = rnd(); end
            if (!b_valid || acc_b) begin b_valid = 1'($urandom_range(0, 1)); b_data = rnd(); end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(posedge clk) #1;
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", out_valid, 0);
        chk("final_sat8", sat8, (nsat > 255) ? 255 : nsat);
        chk("final_sat2", sat2, (nsat > 3) ? 3 : nsat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpcvt_arbiter.md
Name: fpcvt_arbiter

Overview:
- Shares one FPCVT converter (13-bit two's complement in; sign S, 3-bit exponent E, 5-bit mantissa F out) between two independent sample sources, A and B.
- Round-robin arbitration, a registered conversion stage and a valid/ready output with a source tag.
- Keeps a saturating count of saturated results (E=7, F=31).
- Sits between the sample producers and the display/logging path.

Parameters:
- CNT_W, 8, width of sat_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  source A has a sample.
- a_data  in  13  source A sample, two's complement.
- a_ready  out  1  A sample accepted this cycle.
- b_valid  in  1  source B has a sample.
- b_data  in  13  source B sample.
- b_ready  out  1  B sample accepted this cycle.
- out_valid  out  1  converted result available.
- out_ready  in  1  consumer accepts result.
- out_src  out  1  result origin, 0=A, 1=B.
- out_s  out  1  sign.
- out_e  out  3  exponent.
- out_f  out  5  mantissa.
- sat_cnt  out  CNT_W  count of delivered results equal to E=7, F=31.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - Any cycle with rst=1 forces state=IDLE and last_grant=B, so A wins the first tie.
  - Forces out_valid=0, out_src=0, out_s=0, out_e=0, out_f=0, sat_cnt=0 and the capture register to 0.
  - Reset mid-conversion or mid-hold drops the in-flight sample with no output.
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - grant=A if a_valid and not b_valid.
  - grant=B if b_valid and not a_valid.
  - If both are valid, grant goes to the source not equal to last_grant.
  - a_ready = IDLE and grant==A; b_ready likewise. Ready may depend on valid; both readies are never high together.
  - On a handshake: capture the data and the source tag, update last_grant, go to CONV.
- CONV:
  - The captured sample drives FPCVT combinationally.
  - At the clock edge, S/E/F and the tag are registered into the out_* regs, out_valid is set to 1 and the state moves to HOLD.
- HOLD:
  - out_* are held stable while out_ready=0.
  - When out_valid and out_ready are both 1: out_valid goes to 0, the state goes to IDLE and sat_cnt updates as below.
  - No new sample is accepted during CONV or HOLD; both readies are 0.
- Latency and throughput:
  - Input handshake in cycle N gives out_valid=1 in cycle N+2.
  - Minimum spacing between accepts is 3 cycles.
- sat_cnt:
  - Increments by 1 on each output handshake whose result is E=7, F=31.
  - Saturates at 2^CNT_W-1; it does not wrap.
- Conversion rules:
  - Negative input: magnitude = -D, with -4096 clamped to 4095.
  - lz = leading zeros of the 12-bit magnitude. E = 7-lz for lz<=7, otherwise 0.
  - F is the 5 bits starting at the leading one (or the low 5 bits when E=0).
  - The sixth bit rounds half-up.
  - Mantissa overflow gives F=16, E+1. At E=7 the result saturates to E=7, F=31.
  - Zero gives S=0, E=0, F=0.
- Simultaneous events: when both sources stay valid, grants strictly alternate A, B, A, B.

Decomposition:
- Shared package holds:
  - FSM state encodings.
  - Source tag constants SRC_A=0, SRC_B=1.
  - Data width 13 and result widths 1/3/5.
  - The saturated-result constant E=7, F=31.
- Sub-module: the existing FPCVT, instantiated once with no modification.
- Arbitration logic stays inline.

Test Plan:
- Reset, then A only with a_data=0_0001_1010_0110 (422), out_ready=1 -> a_ready at cycle N, out_valid at N+2 with src=0, S0 E4 F26.
- B only with 1_1110_0101_1010 (-422) -> src=1, S1 E4 F26. Then B with 0_0000_1111_1101 (253) -> S0 E4 F16 (mantissa round-overflow).
- A and B held valid continuously with 0_0000_0110_1110 (110) and 0_0000_0110_1100 (108) -> grants in order A, B, A, B. Results alternate S0 E2 F28 and S0 E2 F27.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_* stable, a_ready=b_ready=0. Then out_ready=1 -> one handshake, IDLE on the next cycle.
- Saturation: 0_1111_1111_1111 and 1_0000_0000_0000 -> E7 F31 with S0 and S1, sat_cnt=2.
- With CNT_W=2, deliver 5 saturated results -> sat_cnt holds 3.
- Edge values: 0 -> S0 E0 F0. 1 -> S0 E0 F1. 1_1111_1111_1111 -> S1 E0 F1.
- Assert rst during CONV -> out_valid stays 0 and sat_cnt=0; the next A request is granted first.
